// File: rtl/errt_pkg.sv
// Shared types and default geometry for the error tracker readout engine.
package errt_pkg;

    localparam int ERRT_NWORDS   = 5;
    localparam int ERRT_WORD_W   = 32;
    localparam int ERRT_ADDR_W   = 12;
    localparam int ERRT_SRAM_LAT = 1;
    localparam int ERRT_ARM_WAIT = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        ADDR    = 3'd2,
        WAIT    = 3'd3,
        SEND    = 3'd4,
        RELEASE = 3'd5
    } errt_rd_state_t;

    // The tracker stays frozen (read held) from arming until the last word is sent.
    function automatic logic errt_holds_read(input errt_rd_state_t s);
        logic r;
        case (s)
            ARM, ADDR, WAIT, SEND: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/error_tracker_readout_if.sv
// Valid/ready word stream from the readout engine toward the host capture path.
interface error_tracker_readout_if #(
    parameter int word_w = errt_pkg::ERRT_WORD_W
) ();
    logic [word_w-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/errt_frame_buffer.sv
// Capture registers for one tracker frame; loaded in a single cycle, read out one word at a time.
module errt_frame_buffer
    import errt_pkg::*;
#(
    parameter int n_words = ERRT_NWORDS,
    parameter int word_w  = ERRT_WORD_W,
    localparam int IDX_W  = (n_words > 1) ? $clog2(n_words) : 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      load,
    input  logic [IDX_W-1:0]          idx,
    input  logic [n_words*word_w-1:0] data_in,
    output logic [word_w-1:0]         data_out
);

    logic [word_w-1:0] words_r [n_words];

    // Capture every word of the frame on the load strobe.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < n_words; k++) begin
                words_r[k] <= {word_w{1'b0}};
            end
        end else if (load) begin
            for (int k = 0; k < n_words; k++) begin
                words_r[k] <= data_in[k*word_w +: word_w];
            end
        end else begin
            for (int k = 0; k < n_words; k++) begin
                words_r[k] <= words_r[k];
            end
        end
    end

    // Word select; out-of-range indices read as zero.
    always_comb begin
        data_out = {word_w{1'b0}};
        if (int'(idx) < n_words) begin
            data_out = words_r[idx];
        end else begin
            data_out = {word_w{1'b0}};
        end
    end

endmodule

// File: rtl/error_tracker_readout.sv
// Error tracker readout: freezes the tracker, walks its frames and streams each frame's words, then re-arms it.
module error_tracker_readout
    import errt_pkg::*;
#(
    parameter int addrwidth = ERRT_ADDR_W,
    parameter int n_words   = ERRT_NWORDS,
    parameter int word_w    = ERRT_WORD_W,
    parameter int sram_lat  = ERRT_SRAM_LAT,
    parameter int arm_wait  = ERRT_ARM_WAIT
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic                      abort,
    input  logic [addrwidth:0]        num_frames,
    output logic [addrwidth-1:0]      errt_addr,
    output logic                      errt_read,
    output logic                      errt_enable,
    input  logic [n_words*word_w-1:0] errt_data,
    error_tracker_readout_if.master   out_if,
    output logic                      busy,
    output logic                      done
);

    localparam int FW      = addrwidth + 1;
    localparam int IDX_W   = (n_words > 1) ? $clog2(n_words) : 1;
    localparam int CNT_MAX = (arm_wait > sram_lat) ? arm_wait : sram_lat;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [FW-1:0]        FRAMES_MAX = {1'b1, {addrwidth{1'b0}}};
    localparam logic [FW-1:0]        FRAME_ONE  = FW'(1);
    localparam logic [addrwidth-1:0] ADDR_MAX   = {addrwidth{1'b1}};
    localparam logic [addrwidth-1:0] ADDR_ONE   = addrwidth'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(n_words - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

    errt_rd_state_t        state_r, next_state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic [FW-1:0]         frame_r, frame_nxt_s, frame_inc_s;
    logic [FW-1:0]         num_r, num_nxt_s;
    logic [addrwidth-1:0]  addr_r, addr_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic                  load_s, accept_s;
    logic                  out_valid_r, errt_read_r, errt_enable_r, busy_r, done_r;
    logic [word_w-1:0]     fb_data_s;

    assign accept_s    = out_valid_r & out_if.out_ready;
    assign frame_inc_s = frame_r + FRAME_ONE;

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        frame_nxt_s  = frame_r;
        num_nxt_s    = num_r;
        addr_nxt_s   = addr_r;
        idx_nxt_s    = idx_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    frame_nxt_s = {FW{1'b0}};
                    addr_nxt_s  = {addrwidth{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_nxt_s   = CNT_W'(arm_wait - 1);
                    num_nxt_s   = (num_frames > FRAMES_MAX) ? FRAMES_MAX : num_frames;
                    if (abort || (num_frames == {FW{1'b0}})) begin
                        next_state_s = RELEASE;
                    end else begin
                        next_state_s = ARM;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARM: begin
                if (abort) begin
                    next_state_s = RELEASE;
                end else if (cnt_r == CNT_ZERO) begin
                    next_state_s = ADDR;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ADDR: begin
                if (abort) begin
                    next_state_s = RELEASE;
                end else begin
                    next_state_s = WAIT;
                    cnt_nxt_s    = CNT_W'(sram_lat - 1);
                end
            end
            WAIT: begin
                if (abort) begin
                    next_state_s = RELEASE;
                end else if (cnt_r == CNT_ZERO) begin
                    next_state_s = SEND;
                    load_s       = 1'b1;
                    idx_nxt_s    = {IDX_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            SEND: begin
                // An aborting word still waits for its accept before the engine stops.
                if (accept_s) begin
                    if (idx_r == IDX_LAST) begin
                        frame_nxt_s = frame_inc_s;
                        idx_nxt_s   = {IDX_W{1'b0}};
                        if (abort || (frame_inc_s == num_r) || (addr_r == ADDR_MAX)) begin
                            next_state_s = RELEASE;
                        end else begin
                            next_state_s = ADDR;
                            addr_nxt_s   = addr_r + ADDR_ONE;
                        end
                    end else begin
                        idx_nxt_s = idx_r + IDX_ONE;
                        if (abort) begin
                            next_state_s = RELEASE;
                        end else begin
                            next_state_s = SEND;
                        end
                    end
                end else begin
                    next_state_s = SEND;
                end
            end
            RELEASE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath counters and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_r         <= CNT_ZERO;
            frame_r       <= {FW{1'b0}};
            num_r         <= {FW{1'b0}};
            addr_r        <= {addrwidth{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            out_valid_r   <= 1'b0;
            errt_read_r   <= 1'b0;
            errt_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            cnt_r         <= cnt_nxt_s;
            frame_r       <= frame_nxt_s;
            num_r         <= num_nxt_s;
            addr_r        <= addr_nxt_s;
            idx_r         <= idx_nxt_s;
            out_valid_r   <= (next_state_s == SEND);
            errt_read_r   <= errt_holds_read(next_state_s);
            errt_enable_r <= (next_state_s == RELEASE);
            busy_r        <= (next_state_s != IDLE);
            done_r        <= (state_r == RELEASE);
        end
    end

    errt_frame_buffer #(
        .n_words (n_words),
        .word_w  (word_w)
    ) u_frame_buffer (
        .clk      (clk),
        .rstb     (rstb),
        .load     (load_s),
        .idx      (idx_r),
        .data_in  (errt_data),
        .data_out (fb_data_s)
    );

    assign out_if.out_data  = fb_data_s;
    assign out_if.out_valid = out_valid_r;
    assign errt_addr        = addr_r;
    assign errt_read        = errt_read_r;
    assign errt_enable      = errt_enable_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_error_tracker_readout.sv
// Scoreboard bench for error_tracker_readout with a latency-1 tracker SRAM model.
module tb_error_tracker_readout;

    localparam int AW = 12;
    localparam int NW = 5;
    localparam int WW = 32;

    logic             clk = 1'b0;
    logic             rstb, start, abort;
    logic [AW:0]      num_frames;
    logic [AW-1:0]    errt_addr;
    logic             errt_read, errt_enable;
    logic [NW*WW-1:0] errt_data;
    logic             busy, done;
    logic             rand_ready;

    error_tracker_readout_if #(.word_w(WW)) out_if ();

    error_tracker_readout #(
        .addrwidth (AW), .n_words (NW), .word_w (WW), .sram_lat (1), .arm_wait (2)
    ) dut (
        .clk (clk), .rstb (rstb), .start (start), .abort (abort), .num_frames (num_frames),
        .errt_addr (errt_addr), .errt_read (errt_read), .errt_enable (errt_enable),
        .errt_data (errt_data), .out_if (out_if), .busy (busy), .done (done)
    );

    always #5 clk = ~clk;

    // Reference content: frame f, word k = {f[7:0], k[7:0], 16'hA5A5}; the last word has a zero low half.
    function automatic logic [WW-1:0] ref_word(input int f, input int k);
        logic [7:0] fb, kb;
        fb = 8'(f);
        kb = 8'(k);
        if (k == NW - 1) return {fb, kb, 16'h0000};
        else             return {fb, kb, 16'hA5A5};
    endfunction

    function automatic logic [NW*WW-1:0] ref_frame(input int f);
        logic [NW*WW-1:0] r;
        for (int k = 0; k < NW; k++) r[k*WW +: WW] = ref_word(f, k);
        return r;
    endfunction

    always @(posedge clk) errt_data <= ref_frame(int'(errt_addr));

    int n_checks = 0;
    int n_pass   = 0;
    logic [WW-1:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor state (written only by the monitor).
    int done_cnt = 0, en_cnt = 0, valid_cnt = 0, acc_cnt = 0, stray_cnt = 0, addr_dec = 0;
    int read_lead = 0, lead_first = 0;
    logic [AW-1:0] last_busy_addr = '0, addr_first = '0;
    logic prev_busy = 1'b0, seen_valid = 1'b0, stall_prev = 1'b0;
    logic [WW-1:0] stall_data = '0;

    always @(negedge clk) begin
        if (!rstb) begin
            stall_prev = 1'b0;
            prev_busy  = 1'b0;
            seen_valid = 1'b0;
            read_lead  = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_if.out_valid, 1);
                check("stall_data", out_if.out_data, stall_data);
            end
            if (out_if.out_valid && out_if.out_ready) begin
                check("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) check("word", out_if.out_data, sb_q.pop_front());
                acc_cnt++;
            end
            stall_prev = out_if.out_valid && !out_if.out_ready;
            stall_data = out_if.out_data;
            if (done) done_cnt++;
            if (errt_enable) en_cnt++;
            if (out_if.out_valid) valid_cnt++;
            if (out_if.out_valid && !busy) stray_cnt++;
            if (busy && prev_busy && (errt_addr < last_busy_addr)) addr_dec++;
            if (busy) last_busy_addr = errt_addr;
            prev_busy = busy;
            if (!busy) begin
                seen_valid = 1'b0;
                read_lead  = 0;
            end else if (errt_read && !out_if.out_valid && !seen_valid) begin
                read_lead++;
            end
            if (out_if.out_valid && !seen_valid) begin
                lead_first = read_lead;
                addr_first = errt_addr;
                seen_valid = 1'b1;
            end
        end
    end

    int d0, e0, v0, s0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_if.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int k = 0; k < NW; k++) sb_q.push_back(ref_word(f, k));
    endtask

    task automatic snap();
        d0 = done_cnt; e0 = en_cnt; v0 = valid_cnt; s0 = stray_cnt;
    endtask

    task automatic pulse_start(input int n, input logic ab);
        num_frames = (AW + 1)'(n);
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic post(input string tag);
        repeat (3) tick();
        check({tag, "_done_pulse"}, done_cnt - d0, 1);
        check({tag, "_enable_pulse"}, en_cnt - e0, 1);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_no_stray_valid"}, stray_cnt - s0, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_read"}, errt_read, 0);
    endtask

    initial begin
        int c, a0, dec0;
        rstb = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
        rand_ready = 1'b0; out_if.out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_if.out_valid, 0);
        check("rst_read", errt_read, 0);
        check("rst_enable", errt_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", errt_addr, 0);
        rstb = 1'b1;
        tick(); tick();

        // Three frames, always ready.
        snap(); push_frames(3);
        pulse_start(3, 1'b0);
        wait_done("f3", 200);
        post("f3");
        check("f3_read_lead", lead_first >= 2, 1);
        check("f3_first_addr", addr_first, 0);
        check("f3_valid_cycles", valid_cnt - v0, 15);

        // Two frames with random backpressure and a start pulse while busy.
        snap(); push_frames(2);
        rand_ready = 1'b1;
        pulse_start(2, 1'b0);
        repeat (6) tick();
        pulse_start(3, 1'b0);
        wait_done("rnd", 400);
        rand_ready = 1'b0; out_if.out_ready = 1'b1;
        post("rnd");

        // Zero frames: release only.
        snap();
        pulse_start(0, 1'b0);
        wait_done("nf0", 2);
        post("nf0");
        check("nf0_no_valid", valid_cnt - v0, 0);

        // Start together with abort from IDLE.
        snap();
        pulse_start(3, 1'b1);
        abort = 1'b0;
        wait_done("sab", 3);
        post("sab");
        check("sab_no_valid", valid_cnt - v0, 0);

        // Abort while frame 1 word 2 is pending.
        snap();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < ((f == 0) ? NW : 3); k++) sb_q.push_back(ref_word(f, k));
        pulse_start(3, 1'b0);
        c = 0;
        while (sb_q.size() != 1 && c < 200) begin tick(); c++; end
        check("abort_reach", sb_q.size(), 1);
        out_if.out_ready = 1'b0;
        abort = 1'b1;
        repeat (3) tick();
        check("abort_hold_valid", out_if.out_valid, 1);
        out_if.out_ready = 1'b1;
        wait_done("abt", 20);
        abort = 1'b0;
        post("abt");

        // Reset in the middle of SEND, then a fresh readout from address 0.
        push_frames(2);
        pulse_start(2, 1'b0);
        c = 0;
        while (sb_q.size() > 7 && c < 200) begin tick(); c++; end
        check("pre_reset_valid", out_if.out_valid, 1);
        rstb = 1'b0;
        #1;
        check("mid_rst_valid", out_if.out_valid, 0);
        check("mid_rst_read", errt_read, 0);
        check("mid_rst_busy", busy, 0);
        sb_q.delete();
        tick(); tick();
        rstb = 1'b1;
        tick(); tick();
        snap(); push_frames(1);
        pulse_start(1, 1'b0);
        wait_done("rr", 100);
        post("rr");
        check("rr_first_addr", addr_first, 0);

        // Oversized frame count saturates to the full address space.
        snap(); a0 = acc_cnt; dec0 = addr_dec;
        push_frames(1 << AW);
        pulse_start((1 << AW) + 1, 1'b0);
        wait_done("sat", (1 << AW) * 12 + 100);
        post("sat");
        check("sat_words", acc_cnt - a0, (1 << AW) * NW);
        check("sat_last_addr", last_busy_addr, 12'hFFF);
        check("sat_no_wrap", addr_dec - dec0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
